data_memory_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single-port 8-bit x 256 data memory.
- Port 0 is the CPU load/store path. Port 1 is a secondary master (debug/loader).
- Each request is latched and driven onto the memory's address/writedata/memread/memwrite pins for exactly one clock edge. Read data is captured on the following edge and returned with a one-cycle ack pulse.
- Round-robin arbitration prevents starvation.

---
 rtl/data_memory_arbiter_pkg.sv | 17 +
 rtl/data_memory_arbiter_rr_arbiter2.sv | 27 ++
 rtl/data_memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths (8-bit x 256 memory)
//   arb_state_t             : sequencer state encoding (IDLE, ISSUE, CAPTURE)
package data_memory_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter (combinational).
//
// Ports:
//   req        input  [1:0]  effective requests, bit N = port N
//   last_grant input         port that won the previous arbitration
//   grant      output [1:0]  one-hot grant, all-zero when nothing requests
//
// The last_grant register lives in the parent so this block stays purely
// combinational.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: the port that did not win last time goes first.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter and sequencer for a single-port synchronous data memory.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   req0/we0/addr0/wdata0      port 0 (CPU) request, write enable, address, write data
//   ack0/rdata0                port 0 one-cycle completion pulse and read data
//   req1/we1/addr1/wdata1      port 1 (debug/loader) request signals
//   ack1/rdata1                port 1 completion pulse and read data
//   mem_address/mem_writedata  address and write data driven to the memory
//   mem_memread/mem_memwrite   one-edge access strobes to the memory
//   mem_readdata               registered read data from the memory
//   busy                       high whenever the sequencer is not IDLE
//
// Handshake: a master raises reqN and holds reqN/weN/addrN/wdataN stable
// until it sees ackN high for one cycle; rdataN is valid while ackN is high.
// The arbiter samples the winner's inputs only on the grant edge, and a port
// whose ack is high in a cycle is not eligible for grant in that same cycle.
//
// Sequence per access: IDLE (grant edge, strobes set) -> ISSUE (memory
// performs the access, strobes cleared) -> CAPTURE (read data latched,
// ack pulsed) -> IDLE.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy
);

    arb_state_t state;
    logic       last_grant;
    logic       gnt_port;
    logic       gnt_we;

    logic [1:0]        eff_req;
    logic [1:0]        grant;
    logic              win_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // A port is masked while its own ack is high, so a master that keeps
    // req asserted across its ack is not re-granted on stale inputs.
    assign eff_req = {req1 & ~ack1, req0 & ~ack0};

    rr_arbiter2 u_rr (
        .req        (eff_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        win_port  = grant[1];
        win_we    = win_port ? we1    : we0;
        win_addr  = win_port ? addr1  : addr0;
        win_wdata = win_port ? wdata1 : wdata0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            busy          <= 1'b0;
            last_grant    <= 1'b1;
            gnt_port      <= 1'b0;
            gnt_we        <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        mem_address   <= win_addr;
                        mem_writedata <= win_wdata;
                        mem_memwrite  <= win_we;
                        mem_memread   <= ~win_we;
                        gnt_port      <= win_port;
                        gnt_we        <= win_we;
                        last_grant    <= win_port;
                        state         <= ISSUE;
                        busy          <= 1'b1;
                    end else begin
                        mem_memread  <= 1'b0;
                        mem_memwrite <= 1'b0;
                    end
                end
                ISSUE: begin
                    // The memory consumes the strobe on this edge; dropping it
                    // here guarantees exactly one strobe edge per access.
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    if (!gnt_we) begin
                        if (gnt_port) rdata1 <= mem_readdata;
                        else          rdata0 <= mem_readdata;
                    end
                    if (gnt_port) ack1 <= 1'b1;
                    else          ack0 <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    state        <= IDLE;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: a registered 8x256 memory
// model, a vector table of single-port accesses, and hand-written sequences
// for arbitration, masking and reset corner cases.
module tb_data_memory_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_address, mem_writedata, mem_readdata;
    logic       mem_memread, mem_memwrite;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int viol        = 0;

    logic [7:0] rd_exp0;
    logic [7:0] rd_exp1;
    logic [8:0] exp_q[$];

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    // Clock / reset block
    always #5 CLK = ~CLK;

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req0          (req0),
        .we0           (we0),
        .addr0         (addr0),
        .wdata0        (wdata0),
        .ack0          (ack0),
        .rdata0        (rdata0),
        .req1          (req1),
        .we1           (we1),
        .addr1         (addr1),
        .wdata1        (wdata1),
        .ack1          (ack1),
        .rdata1        (rdata1),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_memread   (mem_memread),
        .mem_memwrite  (mem_memwrite),
        .mem_readdata  (mem_readdata),
        .busy          (busy)
    );

    // Registered memory without reset; preloaded with addr ^ 0xA5 on the
    // first edge.
    logic [7:0] mem_model [256];
    logic       mem_init = 1'b0;
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 8'(i) ^ 8'hA5;
            mem_init <= 1'b1;
        end else begin
            if (mem_memwrite) mem_model[mem_address] <= mem_writedata;
            if (mem_memread)  mem_readdata <= mem_model[mem_address];
        end
    end

    // Mutual exclusion of acks and strobes, evaluated every cycle.
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            if ((ack0 && ack1) || (mem_memread && mem_memwrite)) viol++;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: one access on one port, checks latency, strobe and read data.
    task automatic do_access(input logic port, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp_rd, input string name);
        int   n = 0;
        int   good_strobes = 0;
        int   bad_strobes = 0;
        logic got = 1'b0;
        logic pins_ok = 1'b1;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        while (!got && n < 12) begin
            step();
            n++;
            if (we ? mem_memwrite : mem_memread) begin
                good_strobes++;
                if (mem_address !== addr) pins_ok = 1'b0;
                if (we && mem_writedata !== wdata) pins_ok = 1'b0;
            end
            if (we ? mem_memread : mem_memwrite) bad_strobes++;
            if (port ? ack1 : ack0) got = 1'b1;
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
        if (!we) begin
            if (port) rd_exp1 = exp_rd; else rd_exp0 = exp_rd;
        end
        check({name, " latency"}, 16'(n), 16'd3);
        check({name, " strobe"}, 16'(good_strobes), 16'd1);
        check({name, " wrong_strobe"}, 16'(bad_strobes), 16'd0);
        check({name, " pins"}, {15'd0, pins_ok}, 16'd1);
        check({name, " rdata"}, {8'd0, port ? rdata1 : rdata0}, {8'd0, port ? rd_exp1 : rd_exp0});
        step();
    endtask

    initial begin
        int   t0, t1, n, cnt0, cnt1, total, t_ack_a, t_ack_b, t_rd_a, t_rd_b;
        logic flag;
        logic [8:0] e;

        vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hC3, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hC3};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h3C, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h3C};
        vecs[6] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'hA4};
        vecs[7] = '{1'b1, 1'b0, 8'hFE, 8'h00, 8'h5B};
        vecs[8] = '{1'b0, 1'b1, 8'h80, 8'h00, 8'h00};
        vecs[9] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h00};

        RESET = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        rd_exp0 = 8'h00; rd_exp1 = 8'h00;
        step(); step();

        // Reset state
        check("reset acks", {14'd0, ack0, ack1}, 16'd0);
        check("reset busy", {15'd0, busy}, 16'd0);
        check("reset strobes", {14'd0, mem_memread, mem_memwrite}, 16'd0);
        check("reset mem_pins", {mem_address, mem_writedata}, 16'd0);
        check("reset rdata", {rdata0, rdata1}, 16'd0);
        RESET = 1'b0;
        step();

        // Simultaneous requests right after reset: port 0 wins the first tie.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
        t0 = 0; t1 = 0; n = 0;
        while ((t0 == 0 || t1 == 0) && n < 15) begin
            step();
            n++;
            if (ack0) begin t0 = n; req0 = 1'b0; end
            if (ack1) begin t1 = n; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie ack0 time", 16'(t0), 16'd3);
        check("tie ack1 time", 16'(t1), 16'd6);
        check("tie rdata0", {8'd0, rdata0}, 16'h00A5);
        check("tie rdata1", {8'd0, rdata1}, 16'h005A);
        rd_exp0 = 8'hA5; rd_exp1 = 8'h5A;
        step();

        // Table-driven single-port accesses
        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // Both ports request continuously: grants alternate starting with port 0.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, 8'h85});
            exp_q.push_back({1'b1, 8'h84});
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h21;
        cnt0 = 0; cnt1 = 0; total = 0; n = 0;
        while (total < 8 && n < 60) begin
            step();
            n++;
            if (ack0 || ack1) begin
                total++;
                if (ack0) cnt0++; else cnt1++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
                check($sformatf("rr ack%0d", total), {7'd0, ack1, ack1 ? rdata1 : rdata0}, {7'd0, e});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr total acks", 16'(total), 16'd8);
        check("rr port0 acks", 16'(cnt0), 16'd4);
        check("rr port1 acks", 16'(cnt1), 16'd4);
        step();
        rd_exp0 = 8'h85; rd_exp1 = 8'h84;

        // Request withdrawn before any edge sees it: no access at all.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h33; wdata0 = 8'hEE;
        #3;
        req0 = 1'b0;
        flag = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy || ack0 || ack1 || mem_memread || mem_memwrite) flag = 1'b1;
        end
        check("dropped req idle", {15'd0, flag}, 16'd0);

        // Port 0 holds req across its ack: masked one cycle, then a fresh access.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
        t_ack_a = 0; t_ack_b = 0; t_rd_a = 0; t_rd_b = 0; n = 0;
        while (t_ack_b == 0 && n < 15) begin
            step();
            n++;
            if (mem_memread) begin
                if (t_rd_a == 0) t_rd_a = n;
                else if (t_rd_b == 0) begin
                    t_rd_b = n;
                    check("hold second address", {8'd0, mem_address}, 16'h0041);
                end
            end
            if (ack0) begin
                if (t_ack_a == 0) begin
                    t_ack_a = n;
                    check("hold first rdata", {8'd0, rdata0}, 16'h00E5);
                    addr0 = 8'h41;
                end else t_ack_b = n;
            end
        end
        req0 = 1'b0;
        check("hold first ack", 16'(t_ack_a), 16'd3);
        check("hold first strobe", 16'(t_rd_a), 16'd1);
        check("hold second strobe", 16'(t_rd_b), 16'd5);
        check("hold second ack", 16'(t_ack_b), 16'd7);
        check("hold second rdata", {8'd0, rdata0}, 16'h00E4);
        rd_exp0 = 8'hE4;
        step();

        // Reset during CAPTURE of a port 1 read.
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
        step();
        check("rst-cap strobe", {15'd0, mem_memread}, 16'd1);
        step();
        check("rst-cap busy before", {15'd0, busy}, 16'd1);
        RESET = 1'b1;
        req1 = 1'b0;
        step();
        check("rst-cap no ack", {14'd0, ack0, ack1}, 16'd0);
        check("rst-cap busy", {15'd0, busy}, 16'd0);
        check("rst-cap strobes", {14'd0, mem_memread, mem_memwrite}, 16'd0);
        RESET = 1'b0;
        rd_exp0 = 8'h00; rd_exp1 = 8'h00;
        step();
        do_access(1'b1, 1'b0, 8'h30, 8'h00, 8'h95, "post-reset p1 read");

        check("ack/strobe exclusivity", 16'(viol), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
